// File: rtl/alu_mdu_if.sv
// Request/response bus of the ALU/MDU: an operand handshake in, a result handshake out.
interface alu_mdu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      alu_ctl;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_out;
   logic            alu_err;
   logic            busy;

   modport master (
      output in_valid, alu_ctl, alu_a, alu_b, out_ready,
      input  in_ready, out_valid, alu_out, alu_err, busy
   );

   modport slave (
      input  in_valid, alu_ctl, alu_a, alu_b, out_ready,
      output in_ready, out_valid, alu_out, alu_err, busy
   );
endinterface

// File: rtl/alu_mdu.sv
// Integer ALU with an iterative multiply/divide unit. Single-cycle ops answer
// one cycle after accept; MUL*/DIV*/REM* iterate for XLEN cycles on operand
// magnitudes and apply the sign/special-case fix-up on the last iteration.
module alu_mdu #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic     clk,
   input  logic     rst,
   alu_mdu_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   localparam logic [4:0] OP_ADD  = 5'h01, OP_SLT  = 5'h02, OP_SLTU = 5'h03, OP_AND  = 5'h04,
                          OP_OR   = 5'h05, OP_XOR  = 5'h06, OP_SLL  = 5'h07, OP_SRL  = 5'h08,
                          OP_SUB  = 5'h09, OP_SRA  = 5'h0A, OP_BEQ  = 5'h0B, OP_BNE  = 5'h0C,
                          OP_BLT  = 5'h0D, OP_BLTU = 5'h0E, OP_BGE  = 5'h0F, OP_BGEU = 5'h10,
                          OP_LUI  = 5'h11, OP_ADDU = 5'h12, OP_MUL  = 5'h13, OP_MULH = 5'h14,
                          OP_MULHSU = 5'h15, OP_MULHU = 5'h16, OP_DIV = 5'h17, OP_DIVU = 5'h18,
                          OP_REM  = 5'h19, OP_REMU = 5'h1A;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [4:0]        op_q;
   logic [XLEN-1:0]   a_q, b_q, opd, res;
   logic [2*XLEN-1:0] prod;
   logic [CW-1:0]     cnt;
   logic              neg_q, err;

   logic              is_mdu, last_iter, a_sgn, b_sgn;
   logic [XLEN-1:0]   a_mag, b_mag, alu_res, mdu_res;
   logic              alu_bad;
   logic [SHW-1:0]    shamt;
   logic [XLEN:0]     mul_sum, div_diff;
   logic [2*XLEN-1:0] prod_nxt, prod_neg;

   assign is_mdu    = (bus.alu_ctl >= OP_MUL) && (bus.alu_ctl <= OP_REMU);
   assign last_iter = (cnt == CW'(XLEN - 1));

   // Operand signs and magnitudes for the iterative unit, taken at accept.
   assign a_sgn = bus.alu_a[XLEN-1] && (bus.alu_ctl inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
   assign b_sgn = bus.alu_b[XLEN-1] && (bus.alu_ctl inside {OP_MULH, OP_DIV, OP_REM});
   assign a_mag = a_sgn ? -bus.alu_a : bus.alu_a;
   assign b_mag = b_sgn ? -bus.alu_b : bus.alu_b;

   // Control state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: accept only in IDLE, leave DONE only on the output handshake.
   always_comb begin
      // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = is_mdu ? BUSY : DONE;
         BUSY:    if (last_iter)    state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Single-cycle ALU, evaluated directly on the incoming request.
   always_comb begin
      alu_res = '0;
      alu_bad = 1'b0;
      shamt   = bus.alu_b[SHW-1:0];
      case (bus.alu_ctl)
         OP_ADD, OP_ADDU: alu_res = bus.alu_a + bus.alu_b;
         OP_SUB:  alu_res = bus.alu_a - bus.alu_b;
         OP_SLT, OP_BLT: alu_res = XLEN'($signed(bus.alu_a) < $signed(bus.alu_b));
         OP_SLTU, OP_BLTU: alu_res = XLEN'(bus.alu_a < bus.alu_b);
         OP_BGE:  alu_res = XLEN'($signed(bus.alu_a) >= $signed(bus.alu_b));
         OP_BGEU: alu_res = XLEN'(bus.alu_a >= bus.alu_b);
         OP_BEQ:  alu_res = XLEN'(bus.alu_a == bus.alu_b);
         OP_BNE:  alu_res = XLEN'(bus.alu_a != bus.alu_b);
         OP_AND:  alu_res = bus.alu_a & bus.alu_b;
         OP_OR:   alu_res = bus.alu_a | bus.alu_b;
         OP_XOR:  alu_res = bus.alu_a ^ bus.alu_b;
         OP_SLL:  alu_res = bus.alu_a << shamt;
         OP_SRL:  alu_res = bus.alu_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(bus.alu_a) >>> shamt);
         OP_LUI:  alu_res = bus.alu_b;
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
         default: alu_bad = 1'b1;
      endcase
   end

   // One iteration step: shift-add for multiply, restoring step for divide
   // ({remainder, quotient} share prod), plus the final sign/special-case fix-up.
   always_comb begin
      mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opd} : '0);
      div_diff = prod[2*XLEN-1:XLEN-1] - {1'b0, opd};
      if (op_q >= OP_DIV) begin
         if (!div_diff[XLEN]) prod_nxt = {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
         else                 prod_nxt = {prod[2*XLEN-2:XLEN-1], prod[XLEN-2:0], 1'b0};
      end else begin
         prod_nxt = {mul_sum, prod[XLEN-1:1]};
      end
      prod_neg = neg_q ? -prod_nxt : prod_nxt;
      case (op_q)
         OP_MUL:  mdu_res = prod_nxt[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: mdu_res = prod_neg[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:
            if (b_q == '0) mdu_res = '1;
            else           mdu_res = neg_q ? -prod_nxt[XLEN-1:0] : prod_nxt[XLEN-1:0];
         OP_REM, OP_REMU:
            if (b_q == '0) mdu_res = a_q;
            else           mdu_res = neg_q ? -prod_nxt[2*XLEN-1:XLEN] : prod_nxt[2*XLEN-1:XLEN];
         default: mdu_res = '0;
      endcase
   end

   // Operand latches, iteration datapath and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         opd   <= '0;
         prod  <= '0;
         cnt   <= '0;
         neg_q <= 1'b0;
         res   <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               op_q <= bus.alu_ctl;
               a_q  <= bus.alu_a;
               b_q  <= bus.alu_b;
               cnt  <= '0;
               if (is_mdu) begin
                  prod  <= {{XLEN{1'b0}}, a_mag};
                  opd   <= b_mag;
                  neg_q <= (bus.alu_ctl == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
                  err   <= 1'b0;
               end else begin
                  res <= alu_res;
                  err <= alu_bad;
               end
            end
            BUSY: begin
               prod <= prod_nxt;
               cnt  <= cnt + CW'(1);
               if (last_iter) res <= mdu_res;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.busy      = (state == BUSY);
   assign bus.out_valid = (state == DONE);
   assign bus.alu_out   = res;
   assign bus.alu_err   = err;
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand/result width; power of two, at least 8.
REQ-002 The block SHALL have parameter SHW, default $clog2(XLEN): number of alu_b LSBs used as the shift amount.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-004 Port clk: input, 1 bit, the only clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit, synchronous active-high reset.
REQ-006 Port in_valid: input, 1 bit, request present.
REQ-007 Port in_ready: output, 1 bit, block can accept a request.
REQ-008 Port alu_ctl: input, 5 bits, operation code.
REQ-009 Port alu_a: input, XLEN bits, operand A.
REQ-010 Port alu_b: input, XLEN bits, operand B.
REQ-011 Port out_valid: output, 1 bit, result present.
REQ-012 Port out_ready: input, 1 bit, consumer takes the result.
REQ-013 Port alu_out: output, XLEN bits, result.
REQ-014 Port alu_err: output, 1 bit, the current result came from an undefined opcode.
REQ-015 Port busy: output, 1 bit, high while an iterative operation is in progress.

Function
REQ-016 Opcodes SHALL be ADD=01, SLT=02, SLTU=03, AND=04, OR=05, XOR=06, SLL=07, SRL=08, SUB=09, SRA=0A, BEQ=0B, BNE=0C, BLT=0D, BLTU=0E, BGE=0F, BGEU=10, LUI=11, ADDU=12, MUL=13, MULH=14, MULHSU=15, MULHU=16, DIV=17, DIVU=18, REM=19, REMU=1A (hex).
REQ-017 Compare and branch ops SHALL return 1 or 0, zero-extended to XLEN; LUI SHALL return alu_b; ADD and ADDU SHALL return the modulo-2^XLEN sum.
REQ-018 Shifts SHALL use only alu_b[SHW-1:0]; SRA SHALL replicate alu_a[XLEN-1]; SRL and SLL SHALL fill with zeros.
REQ-019 The FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE with rst low; busy SHALL be 1 only in BUSY.
REQ-020 Accept: in IDLE, when in_valid is high, the block SHALL latch alu_ctl, alu_a and alu_b.
REQ-021 On accept of a single-cycle op (01-12 or undefined), the block SHALL go to DONE; out_valid SHALL rise in the next cycle (latency 1).
REQ-022 On accept of an op 13-1A, the block SHALL go to BUSY and run a radix-2 shift-add or restoring-divide for exactly XLEN cycles, then go to DONE; out_valid SHALL rise XLEN+1 cycles after accept.
REQ-023 MUL SHALL return the low XLEN bits of the product.
REQ-024 MULH, MULHSU and MULHU SHALL return the high XLEN bits of the 2*XLEN product, with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-025 DIV and REM SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-026 Division by zero: DIV and DIVU SHALL return all ones; REM and REMU SHALL return the dividend.
REQ-027 Signed overflow (most-negative / -1): DIV SHALL return the most-negative value and REM SHALL return 0.
REQ-028 Division special cases SHALL keep the standard XLEN+1 latency.
REQ-029 DONE: out_valid, alu_out and alu_err SHALL hold stable until out_ready is high; on that edge the block SHALL go to IDLE and out_valid SHALL drop.
REQ-030 There SHALL be no bypass from DONE to a new accept in the same cycle; the next accept is possible one cycle after the output handshake.
REQ-031 An undefined opcode SHALL produce alu_out=0 and alu_err=1; alu_err SHALL be 0 for defined opcodes.
REQ-032 in_valid during BUSY or DONE SHALL be ignored, and the latched operands SHALL be unaffected.

Reset
REQ-033 With rst high at an edge, the block SHALL set state=IDLE, out_valid=0, alu_out=0, alu_err=0, busy=0 and clear the iteration counter and datapath registers.
REQ-034 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.
REQ-035 Reset during BUSY or DONE SHALL abort the operation; no out_valid SHALL follow for the aborted request.

Verification (XLEN=32)
REQ-036 ADD with A=0x7FFFFFFF, B=0x00000001 -> alu_out=0x80000000, out_valid 1 cycle after accept, alu_err=0.
REQ-037 SRA with A=0x80000000, B=0x00000024 (shift 4) -> 0xF8000000; SLTU with A=0xFFFFFFFF, B=1 -> 0.
REQ-038 MULH with A=B=0x80000000 -> 0x40000000, with out_valid exactly 33 cycles after accept and busy high for 32 cycles.
REQ-039 MULHU with A=B=0xFFFFFFFF -> 0xFFFFFFFE; MUL on the same operands -> 0x00000001.
REQ-040 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
REQ-041 DIVU 5/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; REM -7/2 -> 0xFFFFFFFF (-1).
REQ-042 Backpressure: with out_ready low for 5 cycles in DONE, alu_out and out_valid SHALL stay stable and in_ready SHALL stay 0; after out_ready high, IDLE follows next cycle.
REQ-043 rst pulsed on cycle 10 of a DIVU -> out_valid never rises for that request; in_ready=1 one cycle after rst falls.
REQ-044 alu_ctl=0x1F -> alu_out=0, alu_err=1, latency 1.
